// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_wait data memory.
//   state_t    - controller states (idle, wait-state countdown, response hold)
//   LANE_W     - width of one byte lane
//   lane_count - number of byte lanes in a data word
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int LANE_W = 8;

  function automatic int lane_count(input int data_w);
    return data_w / LANE_W;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W word storage with per-byte write enables,
// combinational read and asynchronous clear of every word on reset.
//   clk      in   clock
//   rst      in   asynchronous active-high reset, clears all words
//   i_we     in   write strobe (already qualified by the controller)
//   i_be     in   byte-lane enables for the write
//   i_addr   in   word address for both read and write
//   i_wdata  in   write data
//   o_rdata  out  mem[i_addr], or 0 when i_addr is out of range
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_we,
  input  logic [lane_count(DATA_W)-1:0] i_be,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic [DATA_W-1:0]             i_wdata,
  output logic [DATA_W-1:0]             o_rdata
);

  localparam int LANES = lane_count(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  // Range guard keeps every access inside the DEPTH words actually built.
  assign w_in_range = ({1'b0, i_addr} < DEPTH_L);
  assign w_idx      = i_addr[IDX_W-1:0];

  // Storage: clear on reset, otherwise write only the enabled lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (i_we && w_in_range) begin
      for (int l = 0; l < LANES; l++) begin
        if (i_be[l]) begin
          r_mem[w_idx][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Combinational read port.
  always_comb begin
    o_rdata = {DATA_W{1'b0}};
    if (w_in_range) begin
      o_rdata = r_mem[w_idx];
    end else begin
      o_rdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/dmem_wait.sv
// dmem_wait: data memory with valid/ready request port, response
// backpressure, byte-enable stores, WAIT programmable wait states and an
// out-of-range error flag. One transaction in flight at a time.
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in idle)
//   req_we, req_be             store select and byte-lane enables
//   req_addr, req_wdata        word address and store data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         load data (0 for stores/errors), range error
module dmem_wait
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16,
  parameter int WAIT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [lane_count(DATA_W)-1:0] req_be,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err
);

  localparam int LANES = lane_count(DATA_W);
  localparam int CNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [LANES-1:0]    r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic                w_acc_fire;
  logic                w_acc_we;
  logic [LANES-1:0]    w_acc_be;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_arr_rdata;
  logic [DATA_W-1:0]   w_rsp_rdata;

  // With no wait states the access happens on the accept edge, so the
  // array sees the live request; otherwise it sees the captured copy.
  assign w_acc_we    = (WAIT == 0) ? req_we    : r_we;
  assign w_acc_be    = (WAIT == 0) ? req_be    : r_be;
  assign w_acc_addr  = (WAIT == 0) ? req_addr  : r_addr;
  assign w_acc_wdata = (WAIT == 0) ? req_wdata : r_wdata;
  assign w_acc_fire  = (WAIT == 0) ? ((r_state == ST_IDLE) && req_valid)
                                   : ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));

  assign w_in_range  = ({1'b0, w_acc_addr} < DEPTH_L);
  assign w_rsp_rdata = (!w_acc_we && w_in_range) ? w_arr_rdata : {DATA_W{1'b0}};

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_acc_fire && w_acc_we && w_in_range),
    .i_be    (w_acc_be),
    .i_addr  (w_acc_addr),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_arr_rdata)
  );

  // Controller FSM: accept, count wait states, perform access, hold response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_W'(0);
      r_we        <= 1'b0;
      r_be        <= {LANES{1'b0}};
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_be    <= req_be;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (WAIT == 0) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_rdata;
              r_rsp_err   <= !w_in_range;
              r_state     <= ST_RESP;
            end else begin
              r_cnt   <= CNT_W'(WAIT);
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= !w_in_range;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait. Three instances share clock, reset and the
// request fields; each has its own req_valid:
//   inst 0: DEPTH=12, WAIT=0   inst 1: DEPTH=16, WAIT=3   inst 2: DEPTH=16, WAIT=2
module tb_dmem_wait;

  logic        clk;
  logic        rst;
  logic        req_we;
  logic [1:0]  req_be;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_ready;
  logic [2:0]  rv;
  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [2:0]  er;
  logic [15:0] rd [3];

  int n_tests;
  int n_fail;

  dmem_wait #(.DATA_W(16), .DEPTH(12), .ADDR_W(16), .WAIT(0)) u_d0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(er[0]));

  dmem_wait #(.DATA_W(16), .DEPTH(16), .ADDR_W(16), .WAIT(3)) u_d1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(er[1]));

  dmem_wait #(.DATA_W(16), .DEPTH(16), .ADDR_W(16), .WAIT(2)) u_d2 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_err(er[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request to instance k from a negedge with k idle; returns at the
  // negedge where rsp_valid is first seen. lat counts rising edges from the
  // accept edge up to and including the one that raised rsp_valid.
  task automatic txn(input int k, input logic we, input logic [1:0] be,
                     input logic [15:0] addr, input logic [15:0] wd,
                     output int lat, output logic [15:0] data, output logic err);
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    rv[k]     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv[k] = 1'b0;
    lat   = 1;
    while (!vld[k] && lat < 20) begin
      chk("busy_req_ready", {31'd0, rdy[k]}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("rsp_req_ready", {31'd0, rdy[k]}, 32'd0);
    data = rd[k];
    err  = er[k];
  endtask

  // Complete the response handshake on instance k and confirm return to idle.
  task automatic done(input int k);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", {31'd0, vld[k]}, 32'd0);
    chk("post_hs_ready", {31'd0, rdy[k]}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic [15:0] d;
    logic        e;
    logic [15:0] held;

    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    rv        = 3'b000;
    req_we    = 1'b0;
    req_be    = 2'b00;
    req_addr  = 16'd0;
    req_wdata = 16'd0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state on all instances.
    chk("rst_ready", {29'd0, rdy}, 32'h7);
    chk("rst_valid", {29'd0, vld}, 32'h0);
    chk("rst_err",   {29'd0, er},  32'h0);
    chk("rst_rdata0", {16'd0, rd[0]}, 32'h0);

    // WAIT=0 load of a cleared word.
    txn(0, 1'b0, 2'b11, 16'd3, 16'd0, lat, d, e);
    chk("w0_load_lat",  lat, 32'd1);
    chk("w0_load_data", {16'd0, d}, 32'h0000);
    chk("w0_load_err",  {31'd0, e}, 32'd0);
    done(0);

    // Full store, then store/load sequences with byte enables.
    txn(0, 1'b1, 2'b11, 16'd5, 16'hBEEF, lat, d, e);
    chk("st_full_rdata", {16'd0, d}, 32'h0000);
    chk("st_full_err",   {31'd0, e}, 32'd0);
    done(0);
    txn(0, 1'b0, 2'b11, 16'd5, 16'd0, lat, d, e);
    chk("ld_beef", {16'd0, d}, 32'hBEEF);
    done(0);
    txn(0, 1'b1, 2'b10, 16'd5, 16'h1200, lat, d, e);
    done(0);
    txn(0, 1'b0, 2'b11, 16'd5, 16'd0, lat, d, e);
    chk("ld_12ef", {16'd0, d}, 32'h12EF);
    done(0);
    txn(0, 1'b1, 2'b00, 16'd5, 16'hFFFF, lat, d, e);
    chk("be0_lat", lat, 32'd1);
    done(0);
    txn(0, 1'b0, 2'b11, 16'd5, 16'd0, lat, d, e);
    chk("be0_unchanged", {16'd0, d}, 32'h12EF);
    done(0);

    // Out-of-range accesses on the DEPTH=12 instance; addr 11 is the last word.
    txn(0, 1'b1, 2'b11, 16'd11, 16'h1111, lat, d, e);
    chk("st11_err", {31'd0, e}, 32'd0);
    done(0);
    txn(0, 1'b1, 2'b11, 16'd14, 16'hDEAD, lat, d, e);
    chk("oor_st_err",   {31'd0, e}, 32'd1);
    chk("oor_st_rdata", {16'd0, d}, 32'h0);
    done(0);
    txn(0, 1'b0, 2'b11, 16'd14, 16'd0, lat, d, e);
    chk("oor_ld_err",   {31'd0, e}, 32'd1);
    chk("oor_ld_rdata", {16'd0, d}, 32'h0);
    done(0);
    txn(0, 1'b0, 2'b11, 16'd11, 16'd0, lat, d, e);
    chk("ld11_data", {16'd0, d}, 32'h1111);
    chk("ld11_err",  {31'd0, e}, 32'd0);
    done(0);
    txn(0, 1'b0, 2'b11, 16'd12, 16'd0, lat, d, e);
    chk("oor_12_err", {31'd0, e}, 32'd1);
    done(0);

    // WAIT=3: latency of 4 cycles, req_ready low throughout.
    txn(1, 1'b1, 2'b11, 16'd7, 16'hCAFE, lat, d, e);
    chk("w3_store_lat", lat, 32'd4);
    done(1);
    rsp_ready = 1'b0;
    txn(1, 1'b0, 2'b11, 16'd7, 16'd0, lat, d, e);
    chk("w3_load_lat",  lat, 32'd4);
    chk("w3_load_data", {16'd0, d}, 32'hCAFE);
    held = d;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", {31'd0, vld[1]}, 32'd1);
      chk("bp_rdata", {16'd0, rd[1]}, {16'd0, held});
      chk("bp_ready", {31'd0, rdy[1]}, 32'd0);
    end
    done(1);

    // WAIT=2: populate addr 2, then abort a second store with reset.
    txn(2, 1'b1, 2'b11, 16'd2, 16'h5555, lat, d, e);
    chk("w2_store_lat", lat, 32'd3);
    done(2);
    req_we    = 1'b1;
    req_be    = 2'b11;
    req_addr  = 16'd2;
    req_wdata = 16'hAAAA;
    rv[2]     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv[2] = 1'b0;
    chk("abort_in_wait", {31'd0, rdy[2]}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_rst_ready", {31'd0, rdy[2]}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'd0, vld[2]}, 32'd0);
      chk("abort_ready",    {31'd0, rdy[2]}, 32'd1);
    end
    txn(2, 1'b0, 2'b11, 16'd2, 16'd0, lat, d, e);
    chk("abort_ld_lat",  lat, 32'd3);
    chk("abort_ld_data", {16'd0, d}, 32'h0000);
    done(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_wait.md
# dmem_wait

Parametrised data memory for the memory-access stage, replacing the fixed 16×16 single-cycle array. It adds a valid/ready request port, response backpressure, per-byte write enables, programmable wait states and an out-of-range error flag. It sits between the ALU result / register read path and write-back, serving one load or store at a time.

## Interface
- DATA_W, 16: word width; multiple of 8.
- DEPTH, 16: number of words; 1 ≤ DEPTH ≤ 2**ADDR_W.
- ADDR_W, 16: address width (word address).
- WAIT, 0: extra wait-state cycles per access; ≥ 0.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_be  in  DATA_W/8  byte enables for store; lane i = bits [8i+7:8i].
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  address ≥ DEPTH.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid && req_ready, capture we/be/addr/wdata.
  - WAIT==0: access performed on the same edge; go to RESP.
  - WAIT>0: load counter with WAIT; go to WAIT.
- WAIT: counter decrements each cycle; on the edge where counter==1, access is performed; go to RESP.
- Access: store writes lanes with be=1 only; be=0 lanes unchanged; be all-zero is a legal no-op store that still responds. Load registers mem[addr] into rsp_rdata.
- Out of range (addr ≥ DEPTH): no write; rsp_rdata=0; rsp_err=1. Otherwise rsp_err=0.
- RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready, then IDLE. No new request is accepted in RESP.
- Reset (any time, including mid-transaction): state IDLE, all DEPTH words cleared to 0, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. An in-flight store whose access edge has not occurred is dropped.
- req_* inputs are ignored outside IDLE.

## Timing
- Accept edge E0 → rsp_valid high in cycle after edge E0+WAIT, i.e. latency WAIT+1 cycles.
- With rsp_ready held high: one transaction per WAIT+2 cycles.
- req_ready is combinational from state only; no path from req_valid to req_ready.
- rsp_valid, rsp_rdata and rsp_err are registered outputs.
- A load issued right after a store to the same address returns the new data; the store is committed before the load's access edge.

## Structure
- Package dmem_pkg: state enum (IDLE, WAIT, RESP), byte-lane width constant 8, and a helper function for lane count (DATA_W/8).
- Sub-module dmem_array: DEPTH×DATA_W storage with byte-enable write, combinational read, and clear-on-reset. The controller FSM, counter and response registers stay in dmem_wait.

## Test plan
- Reset then load addr 3 (WAIT=0) → rsp_valid one cycle after accept, rsp_rdata=16'h0000, rsp_err=0.
- Store 16'hBEEF be=2'b11 to addr 5, then load addr 5 → 16'hBEEF. Then store 16'h1200 be=2'b10 to addr 5 and load → 16'h12EF.
- WAIT=3: load accepted at edge E0 → rsp_valid rises after edge E0+3 (4 cycles). req_ready stays low from E0 until the response handshake completes.
- Hold rsp_ready low for 5 cycles during RESP → rsp_valid and rsp_rdata remain stable and req_ready stays 0. Raising rsp_ready completes the handshake and returns to IDLE.
- DEPTH=12: store to addr 14, then load addr 14 → both give rsp_err=1 and rsp_rdata=0. Load addr 11 still returns its prior value.
- WAIT=2: assert rst during WAIT of a store to addr 2 → after reset, load addr 2 returns 0, rsp_valid did not pulse for the aborted store, and req_ready=1.
